// File: rtl/int_record_deserializer.sv
// int_record_deserializer
// Rebuilds records of NUM_FIELDS signed integer fields from a byte-serial,
// start-of-record framed stream. Byte k of a record lands at m_data[8k +: 8],
// so each field is little-endian and field 0 occupies the low bits.
// A single-entry output register holds the finished record. While that record
// waits for the consumer, s_ready is held low to push back on the byte stream.
// All handshake outputs are registered. No input reaches an output through
// combinational logic only.

module int_record_deserializer #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 32,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    input  logic                          s_sop,
    output logic                          s_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          err_frame,
    output logic [CNT_W-1:0]              rec_count
);

    localparam int REC_W     = NUM_FIELDS * FIELD_W;
    localparam int NUM_BYTES = REC_W / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HOLD
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               s_ready_reg;
    logic               m_valid_reg;
    logic               err_frame_reg;
    logic [CNT_W-1:0]   rec_count_reg;

    // Per-byte decode of the incoming stream
    logic               accept;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               rec_done;
    logic               frame_err;

    // Decode the accepted byte: where it goes, whether it finishes a record,
    // and whether it breaks framing. A byte with s_sop always restarts at
    // lane 0. A byte without s_sop is only kept when a record is already open.
    always_comb begin
        accept    = s_valid && s_ready_reg;
        wr_en     = accept && (s_sop || (state_reg == ST_COLLECT));
        wr_idx    = s_sop ? '0 : idx_reg;
        rec_done  = wr_en && (wr_idx == LAST_IDX);
        frame_err = accept && (((state_reg == ST_IDLE) && !s_sop) ||
                               ((state_reg == ST_COLLECT) && s_sop));
    end

    // Control FSM. It owns every registered handshake output and the
    // delivered-record counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            s_ready_reg   <= 1'b0;
            m_valid_reg   <= 1'b0;
            err_frame_reg <= 1'b0;
            rec_count_reg <= '0;
        end else begin
            // err_frame is a single-cycle pulse per offending byte
            err_frame_reg <= frame_err;
            case (state_reg)
                ST_IDLE, ST_COLLECT: begin
                    s_ready_reg <= 1'b1;
                    if (rec_done) begin
                        state_reg   <= ST_HOLD;
                        s_ready_reg <= 1'b0;
                        m_valid_reg <= 1'b1;
                        idx_reg     <= '0;
                    end else if (wr_en) begin
                        state_reg <= ST_COLLECT;
                        idx_reg   <= wr_idx + IDX_W'(1);
                    end
                end
                ST_HOLD: begin
                    // m_valid is high for the whole of HOLD, so m_ready
                    // alone completes the handshake here
                    if (m_ready) begin
                        state_reg     <= ST_IDLE;
                        m_valid_reg   <= 1'b0;
                        s_ready_reg   <= 1'b1;
                        rec_count_reg <= rec_count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    s_ready_reg <= 1'b0;
                    m_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // One byte-lane register per record byte. A lane changes only when its
    // index is written, so bytes that are not written keep their old value.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Capture the stream byte when this lane is addressed
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= 8'h00;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    lane_reg <= s_data;
                end
            end

            assign m_data[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign s_ready   = s_ready_reg;
    assign m_valid   = m_valid_reg;
    assign err_frame = err_frame_reg;
    assign rec_count = rec_count_reg;

endmodule

// File: tb/tb_int_record_deserializer.sv
// Testbench for int_record_deserializer (3 x 32-bit fields, 4-bit record counter)

module tb_int_record_deserializer;

    localparam int NF = 3;
    localparam int FW = 32;
    localparam int CW = 4;
    localparam int RW = NF * FW;
    localparam int NB = RW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_sop = 1'b0;
    logic          s_ready;
    logic [RW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          err_frame;
    logic [CW-1:0] rec_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    logic [7:0]    cur_q[$];
    logic [RW-1:0] exp_rec = '0;
    int            exp_count = 0;
    bit            auto_ack = 1'b0;
    bit            check_period = 1'b0;
    bit            pending = 1'b0;
    int            last_done_cyc = -1;

    int_record_deserializer #(
        .NUM_FIELDS(NF),
        .FIELD_W   (FW),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_sop    (s_sop),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .err_frame(err_frame),
        .rec_count(rec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record value from its bytes: each field is a little-endian integer
    function automatic logic [RW-1:0] pack_record(input logic [7:0] q[$]);
        logic [RW-1:0] r;
        int unsigned   v;
        r = '0;
        for (int f = 0; f < NF; f++) begin
            v = 0;
            for (int b = FW / 8 - 1; b >= 0; b--) begin
                v = v * 256 + 32'(q[f * (FW / 8) + b]);
            end
            r[f*FW +: FW] = v;
        end
        return r;
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; m_ready = 1'b0;
        auto_ack = 1'b0; check_period = 1'b0; pending = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_s_ready",   RW'(s_ready),   RW'(0));
        check("rst_m_valid",   RW'(m_valid),   RW'(0));
        check("rst_err_frame", RW'(err_frame), RW'(0));
        check("rst_rec_count", RW'(rec_count), RW'(0));
        check("rst_m_data",    m_data,         '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", RW'(s_ready),   RW'(1));
        check("post_rst_err",     RW'(err_frame), RW'(0));
        check("post_rst_m_valid", RW'(m_valid),   RW'(0));
        cur_q.delete();
        exp_count = 0;
        last_done_cyc = -1;
        $display("reset: %0d cycles", cycles);
    endtask

    // Offer one byte; called and returns on a falling edge
    task automatic push(input logic [7:0] b, input bit sop, input int gap);
        int guard;
        bit exp_err;
        for (int i = 0; i < gap; i++) @(negedge clk);
        guard = 0;
        while (s_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_fail++;
            $error("FAIL ready_wait observed=%b expected=1", s_ready);
        end
        s_data = b; s_sop = sop; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_sop = 1'b0; s_data = 8'($urandom);
        if (sop) begin
            exp_err = (cur_q.size() != 0);
            cur_q.delete();
            cur_q.push_back(b);
        end else if (cur_q.size() == 0) begin
            exp_err = 1'b1;
        end else begin
            exp_err = 1'b0;
            cur_q.push_back(b);
        end
        $display("byte %02h sop=%0b err_frame=%0b (exp %0b)", b, sop, err_frame, exp_err);
        check("err_frame", RW'(err_frame), RW'(exp_err));
        if (cur_q.size() == NB) begin
            exp_rec = pack_record(cur_q);
            cur_q.delete();
            check("m_valid_rise", RW'(m_valid), RW'(1));
            check("s_ready_low",  RW'(s_ready), RW'(0));
            check("m_data",       m_data,       exp_rec);
            if (auto_ack) begin
                exp_count = (exp_count + 1) % (1 << CW);
                if (check_period && last_done_cyc >= 0)
                    check("record_period", RW'(cyc - last_done_cyc), RW'(NB + 1));
                last_done_cyc = cyc;
            end else begin
                pending = 1'b1;
            end
        end else begin
            check("m_valid_low", RW'(m_valid), RW'(0));
        end
    endtask

    // Stall the consumer for `hold` cycles, then perform the handshake
    task automatic take(input int hold);
        for (int i = 0; i < hold; i++) begin
            check("hold_m_valid", RW'(m_valid),   RW'(1));
            check("hold_s_ready", RW'(s_ready),   RW'(0));
            check("hold_m_data",  m_data,         exp_rec);
            check("hold_err",     RW'(err_frame), RW'(0));
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        pending = 1'b0;
        exp_count = (exp_count + 1) % (1 << CW);
        $display("record taken after %0d stall cycles, rec_count=%0d (exp %0d)", hold, rec_count, exp_count);
        check("ack_m_valid",   RW'(m_valid),   RW'(0));
        check("ack_s_ready",   RW'(s_ready),   RW'(1));
        check("ack_rec_count", RW'(rec_count), RW'(exp_count));
    endtask

    initial begin
        do_reset(2);

        // Bytes 0x01..0x0C with the consumer always ready. m_ready is held
        // high while nothing is valid and must be ignored.
        m_ready = 1'b1; auto_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_m_ready_ignored", RW'(rec_count), RW'(0));
        end
        for (int k = 0; k < NB; k++) push(8'(k + 1), k == 0, 0);
        check("field0", RW'(m_data[31:0]),  RW'(32'h04030201));
        check("field1", RW'(m_data[63:32]), RW'(32'h08070605));
        check("field2", RW'(m_data[95:64]), RW'(32'h0C0B0A09));
        @(negedge clk);
        check("t1_rec_count", RW'(rec_count), RW'(1));
        check("t1_s_ready",   RW'(s_ready),   RW'(1));
        m_ready = 1'b0; auto_ack = 1'b0;

        // Consumer stalls for 20 cycles
        for (int k = 0; k < NB; k++) push(8'($urandom), k == 0, 0);
        take(20);

        // s_sop on byte 6 restarts the record
        do_reset(2);
        for (int k = 1; k <= 5; k++) push(8'($urandom), k == 1, 0);
        push(8'($urandom), 1'b1, 0);
        for (int k = 0; k < NB - 1; k++) push(8'($urandom), 1'b0, 0);
        take(0);

        // Three stray bytes from IDLE, then a good record
        do_reset(2);
        for (int k = 0; k < 3; k++) push(8'($urandom), 1'b0, 0);
        for (int k = 0; k < NB; k++) push(8'($urandom), k == 0, 0);
        take(1);

        // 17 records back to back: counter wraps and the period is N+1
        do_reset(2);
        m_ready = 1'b1; auto_ack = 1'b1; check_period = 1'b1;
        for (int r = 0; r < 17; r++)
            for (int k = 0; k < NB; k++) push(8'($urandom), k == 0, 0);
        @(negedge clk);
        check("wrap_rec_count", RW'(rec_count), RW'(1));
        check("wrap_model",     RW'(rec_count), RW'(exp_count));
        m_ready = 1'b0; auto_ack = 1'b0; check_period = 1'b0;

        // Reset after 5 bytes, then a full record
        do_reset(2);
        for (int k = 0; k < 5; k++) push(8'($urandom), k == 0, 0);
        do_reset(3);
        for (int k = 0; k < NB; k++) push(8'($urandom), k == 0, 0);
        take(0);

        // Reset while a record is held
        for (int k = 0; k < NB; k++) push(8'($urandom), k == 0, 0);
        do_reset(2);

        // Random traffic: truncated records, stray bytes, gaps, stalls
        for (int r = 0; r < 25; r++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                push(8'($urandom), 1'b0, 0);
                if (pending) take(int'($urandom_range(0, 3)));
            end
            len = (kind == 1) ? int'($urandom_range(1, NB - 1)) : NB;
            for (int k = 0; k < len; k++) begin
                push(8'($urandom), k == 0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
                if (pending) take(int'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
